// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the dot-product engine and its lane datapath.
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMPUTE,
    ST_RESULT
  } state_t;

  // Wide enough for DEPTH full-scale products without overflow.
  function automatic int calc_acc_w(input int data_w, input int depth);
    return 2 * data_w + $clog2(depth);
  endfunction

  // Holds every length from 0 to DEPTH inclusive.
  function automatic int calc_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dp_lane_mac.sv
// Combinational LANES-wide multiply and reduce: masked products summed into one
// ACC_W-bit partial sum per compute cycle.
module dp_lane_mac #(
  parameter int DATA_W = 32,
  parameter int LANES  = 1,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic [LANES-1:0][DATA_W-1:0] a,
  input  logic [LANES-1:0][DATA_W-1:0] b,
  input  logic [LANES-1:0]             lane_en,
  output logic [ACC_W-1:0]             sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic [ACC_W-1:0] term [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic              sa;
    logic              sb;
    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;

    // Extending operands to the product width first makes the low PROD_W bits
    // of the multiply correct for both signed and unsigned operands.
    assign sa   = (SIGNED != 0) && a[k][DATA_W-1];
    assign sb   = (SIGNED != 0) && b[k][DATA_W-1];
    assign a_x  = {{DATA_W{sa}}, a[k]};
    assign b_x  = {{DATA_W{sb}}, b[k]};
    assign prod = a_x * b_x;

    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = {{(ACC_W - PROD_W){(SIGNED != 0) && prod[PROD_W-1]}}, prod};
    end else begin : g_noext
      assign prod_ext = prod;
    end

    assign term[k] = lane_en[k] ? prod_ext : '0;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + term[k];
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product core: loads two vectors over a valid/ready stream, reduces them
// LANES elements per cycle and presents the sum on a valid/ready result port.
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int LANES  = 1,
  parameter int SIGNED = 0,
  parameter int ACC_W  = calc_acc_w(DATA_W, DEPTH),
  parameter int LEN_W  = calc_len_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   idx;
  logic [ACC_W-1:0]   acc;

  logic [DATA_W-1:0]  mem_a [DEPTH];
  logic [DATA_W-1:0]  mem_b [DEPTH];

  logic [LANES-1:0][DATA_W-1:0] lane_a;
  logic [LANES-1:0][DATA_W-1:0] lane_b;
  logic [LANES-1:0]             lane_en;
  logic [ACC_W-1:0]             partial;

  logic len_ok;
  logic beat;
  logic compute_done;

  assign in_ready = (state == ST_FILL);
  assign busy     = (state != ST_IDLE);
  assign res_data = acc;

  assign len_ok       = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
  assign beat         = in_ready && in_valid;
  // One extra bit keeps idx + LANES from wrapping before the comparison.
  assign compute_done = ({1'b0, idx} + (LEN_W + 1)'(LANES)) >= {1'b0, len};

  // NOTE: the vector buffers have no reset; their contents are only read after
  // a full load, so clearing them would add reset fan-out and buy nothing.
  always_ff @(posedge clk) begin
    if (beat && !abort) begin
      mem_a[cnt[AW-1:0]] <= in_a;
      mem_b[cnt[AW-1:0]] <= in_b;
    end
  end

  // Lanes past the end of the vector read whatever the buffer holds and are
  // masked to zero inside the MAC.
  always_comb begin
    lane_a  = '0;
    lane_b  = '0;
    lane_en = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [LEN_W:0] rd_addr;
      rd_addr    = {1'b0, idx} + (LEN_W + 1)'(k);
      lane_en[k] = rd_addr < {1'b0, len};
      lane_a[k]  = mem_a[rd_addr[AW-1:0]];
      lane_b[k]  = mem_b[rd_addr[AW-1:0]];
    end
  end

  dp_lane_mac #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SIGNED (SIGNED),
    .ACC_W  (ACC_W)
  ) u_lane_mac (
    .a       (lane_a),
    .b       (lane_b),
    .lane_en (lane_en),
    .sum     (partial)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      cnt       <= '0;
      idx       <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        idx       <= '0;
        acc       <= '0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (len_ok) begin
                len   <= cfg_len;
                cnt   <= '0;
                idx   <= '0;
                acc   <= '0;
                state <= ST_FILL;
              end else begin
                err <= 1'b1;
              end
            end
          end

          ST_FILL: begin
            if (in_valid) begin
              cnt <= cnt + LEN_W'(1);
              if (cnt == len - LEN_W'(1)) begin
                idx   <= '0;
                state <= ST_COMPUTE;
              end
            end
          end

          ST_COMPUTE: begin
            acc <= acc + partial;
            idx <= idx + LEN_W'(LANES);
            if (compute_done) begin
              res_valid <= 1'b1;
              state     <= ST_RESULT;
            end
          end

          ST_RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
